// File: rtl/gray_wptr_ctrl.sv
// Write-side controller for a gray-coded async-FIFO write pointer: sequences counter reset/ce,
// synchronizes the remote read pointer, flags full/overflow. Optional: GRAY_WPTR_CTRL_ALMOST_FULL_EN.
module gray_wptr_ctrl #(
    parameter int ADDR_WIDTH  = 3,
    parameter int SYNC_STAGES = 2,
    parameter int INIT_CYCLES = 4,
    parameter int AF_MARGIN   = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  push_i,
    input  logic                  flush_i,
    input  logic [ADDR_WIDTH:0]   rptr_gray_i,
    input  logic [ADDR_WIDTH:0]   cnt_gray_i,
    input  logic [ADDR_WIDTH:0]   cnt_bin_i,
    output logic                  cnt_rst_o,
    output logic                  cnt_ce_o,
    output logic                  wr_en_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic                  ready_o,
    output logic                  full_o,
    output logic                  almost_full_o,
    output logic                  overflow_o
);
    localparam int AW = ADDR_WIDTH;
    localparam int CW = $clog2(INIT_CYCLES + 1);
    localparam logic [CW-1:0] INIT_LAST = CW'(INIT_CYCLES - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t                        state, state_nxt;
    logic [CW-1:0]                 init_cnt;
    logic [SYNC_STAGES-1:0][AW:0]  rptr_pipe;
    logic [AW:0]                   rptr_sync;
    logic                          full_cmp;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) rptr_pipe <= '0;
        else          rptr_pipe <= {rptr_pipe[SYNC_STAGES-2:0], rptr_gray_i};
    end
    assign rptr_sync = rptr_pipe[SYNC_STAGES-1];

    // Full when the write pointer is exactly one lap ahead: top two gray bits inverted.
    assign full_cmp  = cnt_gray_i == {~rptr_sync[AW:AW-1], rptr_sync[AW-2:0]};
    assign ready_o   = state == RUN;
    assign cnt_rst_o = state == INIT;
    assign full_o    = ~ready_o | full_cmp;
    assign cnt_ce_o  = push_i & ready_o & ~full_cmp;
    assign wr_en_o   = cnt_ce_o;
    assign wr_addr_o = cnt_bin_i[AW-1:0];

    always_comb begin
        state_nxt = state;
        case (state)
            INIT: if (!flush_i && init_cnt == INIT_LAST) state_nxt = RUN;
            RUN:  if (flush_i) state_nxt = INIT;
            default: state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= INIT;
            init_cnt   <= '0;
            overflow_o <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == INIT && !flush_i) init_cnt <= init_cnt + 1'b1;
            else                           init_cnt <= '0;
            if (state == RUN && flush_i)                   overflow_o <= 1'b0;
            else if (state == RUN && push_i && full_cmp)   overflow_o <= 1'b1;
        end
    end

`ifdef GRAY_WPTR_CTRL_ALMOST_FULL_EN
    localparam logic [AW:0] AF_THR = (AW+1)'((2**AW) - AF_MARGIN);

    logic [AW:0] rptr_bin;
    logic [AW:0] level_nxt;
    logic        af_q;

    for (genvar i = 0; i <= AW; i++) begin : g_g2b
        assign rptr_bin[i] = ^rptr_sync[AW:i];
    end

    // Look ahead by this cycle's write so the flag lines up with the counter update.
    assign level_nxt = cnt_bin_i + {{AW{1'b0}}, cnt_ce_o} - rptr_bin;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)                af_q <= 1'b0;
        else if (state_nxt == INIT)  af_q <= 1'b1;
        else                         af_q <= level_nxt >= AF_THR;
    end
    assign almost_full_o = af_q;
`else
    logic unused_bin_msb;
    assign unused_bin_msb = cnt_bin_i[AW];
    assign almost_full_o  = 1'b0;
`endif

endmodule

// File: tb/tb_gray_wptr_ctrl.sv
// Directed bench for gray_wptr_ctrl with a behavioural gray counter closing the loop.
module tb_gray_wptr_ctrl;
    localparam int AW = 3;
`ifdef GRAY_WPTR_CTRL_ALMOST_FULL_EN
    localparam bit AF_EN = 1'b1;
`else
    localparam bit AF_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          push, flush;
    logic [AW:0]   rptr_gray;
    logic [AW:0]   cbin = '0;
    logic [AW:0]   cgray;
    logic          cnt_rst, cnt_ce, wr_en, ready, full, af, ovf;
    logic [AW-1:0] wr_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (cnt_rst)     cbin <= '0;
        else if (cnt_ce) cbin <= cbin + 1'b1;
    end
    assign cgray = cbin ^ (cbin >> 1);

    gray_wptr_ctrl #(.ADDR_WIDTH(AW), .SYNC_STAGES(2), .INIT_CYCLES(4), .AF_MARGIN(2)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .push_i(push), .flush_i(flush),
        .rptr_gray_i(rptr_gray), .cnt_gray_i(cgray), .cnt_bin_i(cbin),
        .cnt_rst_o(cnt_rst), .cnt_ce_o(cnt_ce), .wr_en_o(wr_en), .wr_addr_o(wr_addr),
        .ready_o(ready), .full_o(full), .almost_full_o(af), .overflow_o(ovf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; push = 1'b0; flush = 1'b0; rptr_gray = '0;
        repeat (3) step();
        chk("rst_cnt_rst", cnt_rst, 1);
        chk("rst_ready", ready, 0);
        chk("rst_full", full, 1);
        chk("rst_ce", cnt_ce, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_af", af, 0);

        // init window, pushes ignored
        rst_n = 1'b1; push = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("init_cnt_rst", cnt_rst, 1);
            chk("init_full", full, 1);
            chk("init_ce", cnt_ce, 0);
            step();
        end
        push = 1'b0; #1;
        chk("run_ready", ready, 1);
        chk("run_cnt_rst", cnt_rst, 0);
        chk("run_full", full, 0);
        chk("run_gray", cgray, 4'b0000);
        chk("run_ovf", ovf, 0);

        // fill to full
        for (int i = 0; i < 8; i++) begin
            push = 1'b1; #1;
            chk("fill_addr", wr_addr, i);
            chk("fill_wr_en", wr_en, 1);
            step();
        end
        #1;
        chk("full_gray", cgray, 4'b1100);
        chk("full_flag", full, 1);
        chk("full_ce", cnt_ce, 0);
        step();
        chk("ovf_set", ovf, 1);
        chk("ovf_gray_hold", cgray, 4'b1100);
        push = 1'b0;
        step();
        chk("ovf_sticky", ovf, 1);

        // read pointer advance, two-cycle sync latency
        rptr_gray = 4'b0001; #1;
        chk("sync_full_0", full, 1);
        step();
        chk("sync_full_1", full, 1);
        step();
        chk("sync_full_2", full, 0);
        push = 1'b1; #1;
        chk("refill_wr_en", wr_en, 1);
        step();
        push = 1'b0; #1;
        chk("refill_gray", cgray, 4'b1101);
        chk("refill_full", full, 1);
        chk("refill_ovf", ovf, 1);

        // flush
        flush = 1'b1; rptr_gray = '0;
        step();
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("flush_cnt_rst", cnt_rst, 1);
            chk("flush_ready", ready, 0);
            chk("flush_ovf", ovf, 0);
            chk("flush_full", full, 1);
            chk("flush_af", af, AF_EN);
            step();
        end
        chk("reinit_ready", ready, 1);
        chk("reinit_bin", cbin, 0);
        chk("reinit_gray", cgray, 0);
        chk("reinit_full", full, 0);
        chk("reinit_af", af, 0);

        // almost-full threshold at level 6
        for (int k = 1; k <= 6; k++) begin
            push = 1'b1; #1;
            chk("af_wr_en", wr_en, 1);
            step();
            push = 1'b0; #1;
            chk("af_level", af, (AF_EN && k >= 6) ? 1 : 0);
        end

        // push and flush together: write lands, then INIT
        push = 1'b1; flush = 1'b1; #1;
        chk("pf_wr_en", wr_en, 1);
        chk("pf_addr", wr_addr, 6);
        step();
        push = 1'b0; flush = 1'b0; #1;
        chk("pf_cnt_rst", cnt_rst, 1);
        chk("pf_bin", cbin, 7);
        chk("pf_ready", ready, 0);
        step();
        chk("pf_bin_clr", cbin, 0);
        repeat (4) step();
        chk("pf_ready_again", ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
